// File: rtl/hsi_monitor_arbiter_pkg.sv
// Shared types and constants for the monitor-frame arbiter and its reader.
package hsi_monitor_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WAIT_LB = 2'd2,
    ST_GAP     = 2'd3
  } arb_state_t;

  localparam logic SRC_MSTR = 1'b0;
  localparam logic SRC_SLV  = 1'b1;

  // Header addresses the reader uses for master/slave monitor frames
  localparam logic [7:0] MON_ADDR_MSTR = 8'h0B;
  localparam logic [7:0] MON_ADDR_SLV  = 8'h09;

  // Single requester wins outright; a tie goes to whoever did not win last.
  function automatic logic pick_winner(logic m_req, logic s_req, logic last);
    if (m_req && s_req) return ~last;
    return s_req ? SRC_SLV : SRC_MSTR;
  endfunction

endpackage

// File: rtl/hsi_monitor_arbiter_if.sv
// Bus bundle between the arbiter, the two monitor FIFOs and the frame reader.
interface hsi_monitor_arbiter_if;
  logic        m_frame_rdy, s_frame_rdy;
  logic [10:0] m_usedw, s_usedw;
  logic [7:0]  m_d, s_d;
  logic        m_rdreq, s_rdreq;
  logic        m_frame_ack, s_frame_ack;
  logic        rd_rdy, rdreq, last_byte;
  logic [10:0] usedw;
  logic [7:0]  d;
  logic        last_frame_src, busy, tmo_err;
  logic        cnt_clr;
  logic [15:0] m_frames, s_frames;

  // master: the arbiter itself
  modport master (
    input  m_frame_rdy, s_frame_rdy, m_usedw, s_usedw, m_d, s_d,
    input  rdreq, last_byte, cnt_clr,
    output m_rdreq, s_rdreq, m_frame_ack, s_frame_ack, rd_rdy,
    output usedw, d, last_frame_src, busy, tmo_err, m_frames, s_frames
  );

  // slave: FIFOs, reader and status consumer
  modport slave (
    output m_frame_rdy, s_frame_rdy, m_usedw, s_usedw, m_d, s_d,
    output rdreq, last_byte, cnt_clr,
    input  m_rdreq, s_rdreq, m_frame_ack, s_frame_ack, rd_rdy,
    input  usedw, d, last_frame_src, busy, tmo_err, m_frames, s_frames
  );
endinterface

// File: rtl/hsi_sat_counter.sv
// Saturating up-counter; clear wins over a same-cycle increment.
module hsi_sat_counter #(
  parameter int         W    = 16,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                q <= INIT;
    else if (clr)              q <= '0;
    else if (inc && ~&q)       q <= q + 1'b1;
  end

endmodule

// File: rtl/hsi_monitor_arbiter.sv
// Round-robin arbiter sharing one monitor-frame reader between master and slave FIFOs.
module hsi_monitor_arbiter
  import hsi_monitor_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int TMO_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  n_rst,
  hsi_monitor_arbiter_if.master bus
);

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam arb_state_t  END_ST   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  arb_state_t  state_q, state_d;
  logic [15:0] wd_q, wd_d;
  logic [15:0] gap_q, gap_d;
  logic        last_grant_q, last_grant_d;
  logic        src_q, src_d;
  logic        rd_rdy_q, rd_rdy_d;
  logic        busy_q, busy_d;
  logic        m_ack_q, m_ack_d;
  logic        s_ack_q, s_ack_d;
  logic        tmo_q, tmo_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      wd_q         <= '0;
      gap_q        <= '0;
      last_grant_q <= SRC_SLV;
      src_q        <= SRC_MSTR;
      rd_rdy_q     <= 1'b0;
      busy_q       <= 1'b0;
      m_ack_q      <= 1'b0;
      s_ack_q      <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      gap_q        <= gap_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      rd_rdy_q     <= rd_rdy_d;
      busy_q       <= busy_d;
      m_ack_q      <= m_ack_d;
      s_ack_q      <= s_ack_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    gap_d        = gap_q;
    last_grant_d = last_grant_q;
    src_d        = src_q;
    rd_rdy_d     = 1'b0;
    busy_d       = busy_q;
    m_ack_d      = 1'b0;
    s_ack_d      = 1'b0;
    tmo_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.m_frame_rdy || bus.s_frame_rdy) begin
          src_d        = pick_winner(bus.m_frame_rdy, bus.s_frame_rdy, last_grant_q);
          last_grant_d = src_d;
          rd_rdy_d     = 1'b1;
          busy_d       = 1'b1;
          state_d      = ST_GRANT;
        end
      end
      ST_GRANT: begin
        wd_d    = '0;
        state_d = ST_WAIT_LB;
      end
      ST_WAIT_LB: begin
        // last_byte outranks an expiring watchdog in the same cycle
        if (bus.last_byte) begin
          m_ack_d = (src_q == SRC_MSTR);
          s_ack_d = (src_q == SRC_SLV);
          busy_d  = 1'b0;
          gap_d   = '0;
          state_d = END_ST;
        end else if (wd_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          busy_d  = 1'b0;
          gap_d   = '0;
          state_d = END_ST;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.usedw          = src_q ? bus.s_usedw : bus.m_usedw;
  assign bus.d              = src_q ? bus.s_d     : bus.m_d;
  assign bus.m_rdreq        = bus.rdreq & busy_q & ~src_q;
  assign bus.s_rdreq        = bus.rdreq & busy_q &  src_q;
  assign bus.rd_rdy         = rd_rdy_q;
  assign bus.busy           = busy_q;
  assign bus.last_frame_src = src_q;
  assign bus.m_frame_ack    = m_ack_q;
  assign bus.s_frame_ack    = s_ack_q;
  assign bus.tmo_err        = tmo_q;

  // Counters step on the ack pulse so a clear during the ack wins
  hsi_sat_counter #(.W(16)) u_m_cnt (
    .clk(clk), .n_rst(n_rst), .inc(m_ack_q), .clr(bus.cnt_clr), .q(bus.m_frames)
  );

  hsi_sat_counter #(.W(16)) u_s_cnt (
    .clk(clk), .n_rst(n_rst), .inc(s_ack_q), .clr(bus.cnt_clr), .q(bus.s_frames)
  );

endmodule

// File: doc/hsi_monitor_arbiter.md
Name: hsi_monitor_arbiter

Overview:
- Shares the single monitor-frame reader/transmit path between the master-side and slave-side monitor FIFOs.
- Watches both sources' frame-ready flags and grants one frame at a time, round-robin.
- While a frame is granted, it presents the winner's usedw/data to the reader, routes the reader's rdreq back to that FIFO, and drives last_frame_src.
- Enforces an inter-frame gap, detects stalled frames, and keeps per-source frame counters.

Parameters:
- GAP_CYCLES, 4, idle cycles between end of one frame and the next grant (0 allowed).
- TMO_CYCLES, 65535, maximum cycles from grant to reader's last_byte before abort (1..65535).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- m_frame_rdy  in  1  master monitor FIFO holds at least one complete frame (level)
- s_frame_rdy  in  1  slave monitor FIFO holds at least one complete frame (level)
- m_usedw  in  11  master FIFO fill level
- s_usedw  in  11  slave FIFO fill level
- m_d  in  8  master FIFO read data
- s_d  in  8  slave FIFO read data
- m_rdreq  out  1  read request to master FIFO
- s_rdreq  out  1  read request to slave FIFO
- m_frame_ack  out  1  one-cycle pulse: master frame fully read
- s_frame_ack  out  1  one-cycle pulse: slave frame fully read
- rd_rdy  out  1  one-cycle frame-start pulse to reader
- rdreq  in  1  reader's FIFO read request
- last_byte  in  1  reader's end-of-frame pulse
- usedw  out  11  muxed fill level to reader
- d  out  8  muxed data to reader
- last_frame_src  out  1  0 = master, 1 = slave; selects reader header address
- busy  out  1  a frame is granted and in flight
- tmo_err  out  1  one-cycle pulse on frame abort
- cnt_clr  in  1  synchronous clear of frame counters
- m_frames  out  16  completed master frames, saturating
- s_frames  out  16  completed slave frames, saturating

Behaviour:
- Reset values: all registered outputs 0. State = IDLE. last_frame_src = 0. last_grant = 1, so master wins the first tie.
- FSM states: IDLE, GRANT, WAIT_LB, GAP.
- IDLE:
  - If either *_frame_rdy is high, pick the winner: the only requester, or on a tie the source not equal to last_grant.
  - Next edge: last_frame_src <= winner, last_grant <= winner, rd_rdy <= 1, busy <= 1, state <= GRANT.
- GRANT: lasts exactly one cycle (rd_rdy high). rd_rdy <= 0 and state <= WAIT_LB. Watchdog loads to 0.
- WAIT_LB:
  - Watchdog increments every cycle.
  - On last_byte: pulse the selected *_frame_ack next cycle, increment the selected counter, busy <= 0, then go to GAP, or to IDLE if GAP_CYCLES = 0.
  - On watchdog == TMO_CYCLES-1 without last_byte: pulse tmo_err, busy <= 0, no ack, no count, go to GAP/IDLE as above.
  - last_byte and expiry in the same cycle: treated as normal completion, no tmo_err.
- GAP: counts GAP_CYCLES cycles, then IDLE. Requests are ignored during GAP.
- Muxing is combinational on last_frame_src:
  - usedw/d = selected source's usedw/d, valid in the rd_rdy cycle (the reader latches usedw there).
  - m_rdreq = rdreq & busy & ~last_frame_src; s_rdreq = rdreq & busy & last_frame_src.
  - rdreq while not busy is dropped.
- last_frame_src holds its value after the frame until the next grant.
- Minimum spacing between rd_rdy pulses = 3 + GAP_CYCLES cycles.
- Counters: increment on their ack and saturate at 16'hFFFF. cnt_clr has priority over a same-cycle increment (result 0).
- A frame_rdy drop during WAIT_LB has no effect on the granted frame.
- Reset mid-frame returns everything to reset values asynchronously. No ack is issued.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, GRANT=1, WAIT_LB=2, GAP=3), SRC_MSTR=0, SRC_SLV=1, and the monitor address constants 8'h0B/8'h09 already used by the reader.
- One natural sub-module: hsi_sat_counter (16-bit, inc/clr, clear priority), instantiated twice.

Test Plan:
- Reset, m_frame_rdy=1, m_usedw=11'd5 -> rd_rdy pulse 2 cycles later; usedw=5 and last_frame_src=0 in that cycle; busy=1.
- Both ready continuously with GAP_CYCLES=4 -> grants alternate M,S,M,S; last_frame_src toggles; rd_rdy pulses 7 cycles apart when last_byte follows immediately.
- Slave granted, reader drives rdreq for 3 cycles -> s_rdreq high 3 cycles, m_rdreq stays 0; d mirrors s_d; on last_byte, s_frame_ack pulses and s_frames goes 0->1.
- TMO_CYCLES=8, no last_byte -> tmo_err pulses once, 8 cycles after GRANT ends; busy=0; counters unchanged; a later rdreq is not forwarded.
- m_frames preloaded at 16'hFFFE, two master frames -> 16'hFFFF and stays; cnt_clr coinciding with m_frame_ack -> 0.
- n_rst low during WAIT_LB -> all outputs 0 immediately; after release with both ready, master is granted first.
